// File: rtl/othello_cell_renderer_if.sv
// Request/plot bus between the game datapath (master) and othello_cell_renderer (slave).
interface othello_cell_renderer_if #(
   parameter int CW      = 3,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int COLOR_W = 3
);
   logic               start;
   logic [CW-1:0]      cell_x;
   logic [CW-1:0]      cell_y;
   logic [1:0]         mode;
   logic               busy;
   logic               done;
   logic               err;
   logic               plot;
   logic [X_W-1:0]     x_out;
   logic [Y_W-1:0]     y_out;
   logic [COLOR_W-1:0] colour;

   modport master (
      output start, cell_x, cell_y, mode,
      input  busy, done, err, plot, x_out, y_out, colour
   );

   modport slave (
      input  start, cell_x, cell_y, mode,
      output busy, done, err, plot, x_out, y_out, colour
   );
endinterface

// File: rtl/othello_cell_renderer.sv
// Rasterises one Othello board cell (empty, disk or cursor outline) into vga_adapter plot writes.
// Build option: define OTHELLO_GRID_LINES_EN to draw the border of modes 0/1/2 as black grid lines.
module othello_cell_renderer #(
   parameter int CELL_PX  = 14,
   parameter int BOARD_N  = 8,
   parameter int ORIGIN_X = 4,
   parameter int ORIGIN_Y = 4,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOR_W  = 3
) (
   input logic                    clock,
   input logic                    resetn,
   othello_cell_renderer_if.slave bus
);
   localparam int CW = $clog2(BOARD_N);
   localparam int PW = $clog2(CELL_PX);
   localparam int AW = PW + 1;
   localparam int DW = 2 * AW + 1;

   function automatic logic [COLOR_W-1:0] expandColour(input logic [2:0] c);
      logic [COLOR_W-1:0] o;
      for (int i = 0; i < COLOR_W; i++) o[i] = c[2'((i * 3) / COLOR_W)];
      return o;
   endfunction

   localparam logic [COLOR_W-1:0] C_BG     = expandColour(3'b010);
   localparam logic [COLOR_W-1:0] C_BLACK  = expandColour(3'b000);
   localparam logic [COLOR_W-1:0] C_WHITE  = expandColour(3'b111);
   localparam logic [COLOR_W-1:0] C_CURSOR = expandColour(3'b100);
   localparam logic [PW-1:0]      LAST     = PW'(CELL_PX - 1);
   localparam logic [AW-1:0]      SPAN     = AW'(CELL_PX - 1);
   localparam logic [DW-1:0]      DISK_R2  = DW'((CELL_PX - 3) * (CELL_PX - 3));

   if (CELL_PX < 4) begin : g_badCell
      $error("othello_cell_renderer: CELL_PX must be at least 4");
   end
   if (ORIGIN_X + BOARD_N * CELL_PX > (1 << X_W)) begin : g_badX
      $error("othello_cell_renderer: board does not fit in X_W");
   end
   if (ORIGIN_Y + BOARD_N * CELL_PX > (1 << Y_W)) begin : g_badY
      $error("othello_cell_renderer: board does not fit in Y_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

   state_t             r_state, w_nextState;
   logic [PW-1:0]      r_col, r_row, w_nextCol, w_nextRow;
   logic [CW-1:0]      r_lx, r_ly, w_nextLx, w_nextLy;
   logic [1:0]         r_mode, w_nextMode;
   logic               r_busy, r_done, r_err, r_plot;
   logic [X_W-1:0]     r_x, w_pixX;
   logic [Y_W-1:0]     r_y, w_pixY;
   logic [COLOR_W-1:0] r_colour, w_pixColour;
   logic               w_errHit, w_pixPlot, w_border, w_disk;
   logic [AW-1:0]      w_twoCol, w_twoRow, w_adx, w_ady;
   logic [DW-1:0]      w_adxW, w_adyW, w_dist;

   always_comb begin
      w_nextState = r_state;
      w_nextCol   = r_col;
      w_nextRow   = r_row;
      w_nextLx    = r_lx;
      w_nextLy    = r_ly;
      w_nextMode  = r_mode;
      w_errHit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if ((32'(bus.cell_x) < BOARD_N) && (32'(bus.cell_y) < BOARD_N)) begin
                  w_nextLx    = bus.cell_x;
                  w_nextLy    = bus.cell_y;
                  w_nextMode  = bus.mode;
                  w_nextCol   = '0;
                  w_nextRow   = '0;
                  w_nextState = S_DRAW;
               end else begin
                  w_errHit = 1'b1;
               end
            end
         end
         S_DRAW: begin
            if (r_col == LAST) begin
               w_nextCol = '0;
               if (r_row == LAST) begin
                  w_nextRow   = '0;
                  w_nextState = S_FINISH;
               end else begin
                  w_nextRow = r_row + 1'b1;
               end
            end else begin
               w_nextCol = r_col + 1'b1;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Pixel is derived from the next counter values so the registered plot lines up with the counters.
   always_comb begin
      w_twoCol  = {w_nextCol, 1'b0};
      w_twoRow  = {w_nextRow, 1'b0};
      w_adx     = (w_twoCol >= SPAN) ? (w_twoCol - SPAN) : (SPAN - w_twoCol);
      w_ady     = (w_twoRow >= SPAN) ? (w_twoRow - SPAN) : (SPAN - w_twoRow);
      w_adxW    = DW'(w_adx);
      w_adyW    = DW'(w_ady);
      w_dist    = w_adxW * w_adxW + w_adyW * w_adyW;
      w_disk    = (w_dist <= DISK_R2);
      w_border  = (w_nextCol == '0) || (w_nextCol == LAST) || (w_nextRow == '0) || (w_nextRow == LAST);
      w_pixX    = X_W'(ORIGIN_X) + X_W'(w_nextLx) * X_W'(CELL_PX) + X_W'(w_nextCol);
      w_pixY    = Y_W'(ORIGIN_Y) + Y_W'(w_nextLy) * Y_W'(CELL_PX) + Y_W'(w_nextRow);
      w_pixPlot = 1'b0;
      w_pixColour = C_BG;
      if (w_nextState == S_DRAW) begin
         if (w_nextMode == 2'd3) begin
            w_pixPlot   = w_border;
            w_pixColour = C_CURSOR;
         end else begin
            w_pixPlot = 1'b1;
            if (w_disk && (w_nextMode == 2'd1)) w_pixColour = C_BLACK;
            else if (w_disk && (w_nextMode == 2'd2)) w_pixColour = C_WHITE;
`ifdef OTHELLO_GRID_LINES_EN
            if (w_border) w_pixColour = C_BLACK;
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_col    <= '0;
         r_row    <= '0;
         r_lx     <= '0;
         r_ly     <= '0;
         r_mode   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
      end else begin
         r_state <= w_nextState;
         r_col   <= w_nextCol;
         r_row   <= w_nextRow;
         r_lx    <= w_nextLx;
         r_ly    <= w_nextLy;
         r_mode  <= w_nextMode;
         r_busy  <= (w_nextState == S_DRAW);
         r_done  <= (w_nextState == S_FINISH);
         r_err   <= w_errHit;
         r_plot  <= w_pixPlot;
         if (w_pixPlot) begin
            r_x      <= w_pixX;
            r_y      <= w_pixY;
            r_colour <= w_pixColour;
         end
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.err    = r_err;
   assign bus.plot   = r_plot;
   assign bus.x_out  = r_x;
   assign bus.y_out  = r_y;
   assign bus.colour = r_colour;
endmodule

// File: tb/tb_othello_cell_renderer.sv
// Self-checking bench for othello_cell_renderer: directed and random cell draws against a pixel-rule model.
module tb_othello_cell_renderer;
   localparam int CELL_PX  = 14;
   localparam int ORIGIN_X = 4;
   localparam int ORIGIN_Y = 4;
   localparam int CW       = 3;
   localparam int NPIX     = CELL_PX * CELL_PX;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   nCompared = 0;
   int   nMismatched = 0;

   othello_cell_renderer_if #(.CW(CW), .X_W(8), .Y_W(7), .COLOR_W(3)) bus ();
   othello_cell_renderer_if #(.CW(CW), .X_W(8), .Y_W(7), .COLOR_W(3)) bus2 ();

   othello_cell_renderer #(
      .CELL_PX(CELL_PX), .BOARD_N(8), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
      .X_W(8), .Y_W(7), .COLOR_W(3)
   ) dut (.clock(clock), .resetn(resetn), .bus(bus));

   // Smaller board so that 3-bit coordinates can reach the out-of-range values 6 and 7.
   othello_cell_renderer #(
      .CELL_PX(CELL_PX), .BOARD_N(6), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
      .X_W(8), .Y_W(7), .COLOR_W(3)
   ) dut2 (.clock(clock), .resetn(resetn), .bus(bus2));

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input int cx, input int cy, input int m);
      bus.start  = s;
      bus.cell_x = CW'(cx);
      bus.cell_y = CW'(cy);
      bus.mode   = 2'(m);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference pixel rules: geometry from cell coordinates, shape from squared distance to the centre.
   task automatic modelPixel(input int cx, input int cy, input int m, input int p,
                             output logic ePlot, output int eX, output int eY, output int eC);
      int col, row, dx, dy, d;
      bit disk, border;
      col    = p % CELL_PX;
      row    = p / CELL_PX;
      dx     = 2 * col - (CELL_PX - 1);
      dy     = 2 * row - (CELL_PX - 1);
      d      = dx * dx + dy * dy;
      disk   = (d <= (CELL_PX - 3) * (CELL_PX - 3));
      border = (col == 0) || (row == 0) || (col == CELL_PX - 1) || (row == CELL_PX - 1);
      eX     = ORIGIN_X + cx * CELL_PX + col;
      eY     = ORIGIN_Y + cy * CELL_PX + row;
      if (m == 3) begin
         ePlot = border;
         eC    = 4;
      end else begin
         ePlot = 1'b1;
         if (disk && m == 1) eC = 0;
         else if (disk && m == 2) eC = 7;
         else eC = 2;
`ifdef OTHELLO_GRID_LINES_EN
         if (border) eC = 0;
`endif
      end
   endtask

   // Draws one cell while scrambling the inputs every cycle; abortAt >= 0 pulls reset after that pixel.
   task automatic drawCell(input int cx, input int cy, input int m, input int abortAt);
      logic ePlot;
      int   eX, eY, eC, plots, expPlots;
      plots    = 0;
      expPlots = 0;
      applyStimulus(1'b1, cx, cy, m);
      for (int p = 0; p < NPIX; p++) begin
         step();
         applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
         modelPixel(cx, cy, m, p, ePlot, eX, eY, eC);
         checkOutput("busy", bus.busy, 1);
         checkOutput("done_mid", bus.done, 0);
         checkOutput("plot", bus.plot, ePlot);
         if (ePlot) begin
            checkOutput("x_out", bus.x_out, eX);
            checkOutput("y_out", bus.y_out, eY);
            checkOutput("colour", bus.colour, eC);
            expPlots++;
         end
         if (bus.plot) plots++;
         if (p == abortAt) begin
            resetn = 1'b0;
            step();
            checkOutput("abort_plot", bus.plot, 0);
            checkOutput("abort_busy", bus.busy, 0);
            checkOutput("abort_x", bus.x_out, 0);
            resetn = 1'b1;
            applyStimulus(1'b0, 0, 0, 0);
            for (int k = 0; k < 4; k++) begin
               step();
               checkOutput("abort_no_done", bus.done, 0);
               checkOutput("abort_idle_plot", bus.plot, 0);
            end
            return;
         end
      end
      step();
      checkOutput("done", bus.done, 1);
      checkOutput("busy_finish", bus.busy, 0);
      checkOutput("plot_finish", bus.plot, 0);
      checkOutput("err_finish", bus.err, 0);
      checkOutput("plot_count", plots, expPlots);
      applyStimulus(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      step();
      checkOutput("done_cleared", bus.done, 0);
      checkOutput("start_in_finish_ignored", bus.busy, 0);
      applyStimulus(1'b0, 0, 0, 0);
   endtask

   initial begin
      int seen;
      applyStimulus(1'b0, 0, 0, 0);
      bus2.start  = 1'b0;
      bus2.cell_x = '0;
      bus2.cell_y = '0;
      bus2.mode   = '0;

      resetn = 1'b0;
      step();
      step();
      checkOutput("rst_plot", bus.plot, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_err", bus.err, 0);
      checkOutput("rst_x", bus.x_out, 0);
      checkOutput("rst_y", bus.y_out, 0);
      checkOutput("rst_colour", bus.colour, 0);
      resetn = 1'b1;
      step();

      drawCell(0, 0, 0, -1);
      drawCell(7, 7, 1, -1);
      drawCell(3, 2, 3, -1);
      drawCell(5, 1, 2, -1);
      for (int n = 0; n < 4; n++) begin
         drawCell($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), -1);
      end
      drawCell(2, 6, 1, 49);
      drawCell(4, 4, 2, -1);

      bus2.start  = 1'b1;
      bus2.cell_x = CW'($urandom_range(6, 7));
      bus2.cell_y = CW'($urandom_range(0, 7));
      step();
      bus2.start = 1'b0;
      checkOutput("err_x_pulse", bus2.err, 1);
      checkOutput("err_x_busy", bus2.busy, 0);
      checkOutput("err_x_plot", bus2.plot, 0);
      step();
      checkOutput("err_x_one_cycle", bus2.err, 0);
      checkOutput("err_x_still_idle", bus2.busy, 0);

      bus2.start  = 1'b1;
      bus2.cell_x = CW'($urandom_range(0, 5));
      bus2.cell_y = CW'($urandom_range(6, 7));
      step();
      bus2.start = 1'b0;
      checkOutput("err_y_pulse", bus2.err, 1);
      checkOutput("err_y_busy", bus2.busy, 0);
      step();
      checkOutput("err_y_one_cycle", bus2.err, 0);

      bus2.start  = 1'b1;
      bus2.cell_x = CW'($urandom_range(0, 5));
      bus2.cell_y = CW'($urandom_range(0, 5));
      bus2.mode   = 2'd1;
      step();
      checkOutput("ok_no_err", bus2.err, 0);
      checkOutput("ok_busy", bus2.busy, 1);
      bus2.cell_x = 3'd7;
      step();
      bus2.start = 1'b0;
      checkOutput("busy_start_not_flagged", bus2.err, 0);
      seen = 0;
      for (int k = 0; k < 300 && seen == 0; k++) begin
         if (bus2.done) seen = k + 2;
         else step();
      end
      checkOutput("dut2_done_cycle", seen, NPIX + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
